lcd_video_timing: RTL and testbench

//  Raster timing generator: the driver side of the pixel-counter interface. Produces CounterX/CounterY
//  for pixel generators such as the Pong renderer and takes back their registered RGB. Drives LCD

---
 rtl/lcd_video_pkg.sv | 77 +++++++
 rtl/lcd_video_timing_sync_delay.sv | 49 ++++
 rtl/lcd_video_timing.sv | 188 ++++++++++++++++++
 tb/tb_lcd_video_timing.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_video_pkg.sv
// ---------------------------------------------------------------------------
// lcd_video_pkg
//   Shared definitions for the LCD raster timing generator.
//   - Default 640x480 timing constants and the line/frame total derivation.
//   - COUNTER_W: width of CounterX/CounterY and of every timing compare.
//   - timing_t / rgb_t: packed bundles for {hs,vs,de} and a colour triple.
//   - bar_colour(): the eight-entry vertical colour-bar table.
//   - sync_active()/sync_inactive(): pin level for a given sync polarity.
//   Optional feature macro used by the importing files: LCD_TEST_PATTERN_EN.
// ---------------------------------------------------------------------------
package lcd_video_pkg;

    localparam int COUNTER_W = 12;

    // Default horizontal timing, in pixels.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    // Default vertical timing, in lines.
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic DEF_SYNC_POL    = 1'b0;
    localparam int   DEF_PIX_LATENCY = 1;

    // Widths of the signals carried through the alignment pipeline.
    localparam int TIMING_W = 3;
    localparam int BAR_W    = 3;
    // Colour bars are 128 pixels wide: CounterX[9:7] selects the bar.
    localparam int BAR_LSB  = 7;

    typedef logic [COUNTER_W-1:0] counter_t;

    // Logical (active-high) timing flags; polarity is applied at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } timing_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int line_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = line_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = line_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Bar index bit 2/1/0 drives red/green/blue fully on or off, giving the
    // classic black, blue, green, cyan, red, magenta, yellow, white sequence.
    function automatic rgb_t bar_colour(input logic [BAR_W-1:0] bar);
        rgb_t c;
        c.r = {8{bar[2]}};
        c.g = {8{bar[1]}};
        c.b = {8{bar[0]}};
        return c;
    endfunction

    function automatic logic sync_active(input logic pol);
        return pol;
    endfunction

    function automatic logic sync_inactive(input logic pol);
        return ~pol;
    endfunction

endpackage

// File: rtl/lcd_video_timing_sync_delay.sv
// ---------------------------------------------------------------------------
// lcd_sync_delay
//   LATENCY-deep shift register that lines the raw timing flags (and, when
//   LCD_TEST_PATTERN_EN is defined, the colour-bar index) up with the RGB the
//   renderer returns. Every stage advances only on pix_en and clears to zero
//   on reset; zero is the inactive value of every carried flag.
// Ports
//   clk       in   1      pixel-domain clock
//   reset     in   1      synchronous, active-high
//   pix_en    in   1      stage advance strobe
//   data_in   in   WIDTH  undelayed flags
//   data_out  out  WIDTH  flags LATENCY pix_en cycles later
// ---------------------------------------------------------------------------
module lcd_sync_delay #(
    parameter int LATENCY = 1,
    parameter int WIDTH   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    // chain[0] is the input, chain[LATENCY] the output of the last stage.
    logic [WIDTH-1:0] chain [LATENCY+1];

    assign chain[0] = data_in;

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_reg <= '0;
                end else if (pix_en) begin
                    stage_reg <= chain[gi];
                end
            end

            assign chain[gi+1] = stage_reg;
        end
    endgenerate

    assign data_out = chain[LATENCY];

endmodule

// File: rtl/lcd_video_timing.sv
// ---------------------------------------------------------------------------
// lcd_video_timing
//   Raster timing generator. Publishes CounterX/CounterY to a pixel renderer,
//   accepts the renderer's RGB PIX_LATENCY pix_en cycles later, and drives
//   the panel sync/DE/RGB pins aligned with that returned pixel. Total
//   counter-to-pin latency is PIX_LATENCY+1 pix_en cycles.
// Ports
//   clk, reset          pixel clock; synchronous active-high reset
//   pix_en              pixel strobe, all state advances only when high
//   pattern_sel         colour-bar select (only with LCD_TEST_PATTERN_EN)
//   CounterX/CounterY   12-bit raster position
//   FrameStart          high while at (0,0) and pix_en is high
//   red_in/green_in/blue_in   renderer colour
//   lcd_hsync/lcd_vsync/lcd_de, lcd_r/lcd_g/lcd_b   panel pins
// Configuration
//   LCD_TEST_PATTERN_EN defined: pattern_sel high substitutes eight vertical
//   colour bars for the renderer colour. Undefined: pattern_sel is ignored.
// ---------------------------------------------------------------------------
module lcd_video_timing
    import lcd_video_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_POL    = DEF_SYNC_POL,
    parameter int   PIX_LATENCY = DEF_PIX_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_en,
    input  logic                 pattern_sel,
    output logic [COUNTER_W-1:0] CounterX,
    output logic [COUNTER_W-1:0] CounterY,
    output logic                 FrameStart,
    input  logic [7:0]           red_in,
    input  logic [7:0]           green_in,
    input  logic [7:0]           blue_in,
    output logic                 lcd_hsync,
    output logic                 lcd_vsync,
    output logic                 lcd_de,
    output logic [7:0]           lcd_r,
    output logic [7:0]           lcd_g,
    output logic [7:0]           lcd_b
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // All boundaries are held at full counter width so no compare truncates.
    localparam counter_t H_LAST     = counter_t'(H_TOTAL - 1);
    localparam counter_t V_LAST     = counter_t'(V_TOTAL - 1);
    localparam counter_t H_ACT_END  = counter_t'(H_ACTIVE);
    localparam counter_t V_ACT_END  = counter_t'(V_ACTIVE);
    localparam counter_t HS_START   = counter_t'(H_ACTIVE + H_FP);
    localparam counter_t HS_END     = counter_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam counter_t VS_START   = counter_t'(V_ACTIVE + V_FP);
    localparam counter_t VS_END     = counter_t'(V_ACTIVE + V_FP + V_SYNC);

`ifdef LCD_TEST_PATTERN_EN
    localparam int DLY_W = TIMING_W + BAR_W;
`else
    localparam int DLY_W = TIMING_W;
`endif

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    counter_t x_reg, x_next;
    counter_t y_reg, y_next;

    always_comb begin
        x_next = x_reg + counter_t'(1);
        y_next = y_reg;
        if (x_reg == H_LAST) begin
            x_next = '0;
            // The line counter wraps on the same pixel the column wraps.
            y_next = (y_reg == V_LAST) ? '0 : y_reg + counter_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (pix_en) begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    assign CounterX = x_reg;
    assign CounterY = y_reg;

    // Reset is masked in so the reset cycle never reports a frame start even
    // when the counters already sit at the origin.
    assign FrameStart = pix_en && !reset && (x_reg == '0) && (y_reg == '0);

    // ------------------------------------------------------------------
    // Raw timing decoded from the current counters
    // ------------------------------------------------------------------
    timing_t raw_timing;

    always_comb begin
        raw_timing.de = (x_reg < H_ACT_END) && (y_reg < V_ACT_END);
        raw_timing.hs = (x_reg >= HS_START) && (x_reg < HS_END);
        raw_timing.vs = (y_reg >= VS_START) && (y_reg < VS_END);
    end

    // ------------------------------------------------------------------
    // Alignment pipeline: matches the renderer's PIX_LATENCY
    // ------------------------------------------------------------------
    logic [DLY_W-1:0] dly_in;
    logic [DLY_W-1:0] dly_out;
    timing_t          dly_timing;

`ifdef LCD_TEST_PATTERN_EN
    logic [BAR_W-1:0] dly_bar;

    assign dly_in     = {raw_timing, x_reg[BAR_LSB +: BAR_W]};
    assign dly_bar    = dly_out[BAR_W-1:0];
`else
    assign dly_in     = raw_timing;
`endif
    assign dly_timing = timing_t'(dly_out[DLY_W-1 -: TIMING_W]);

    lcd_sync_delay #(
        .LATENCY (PIX_LATENCY),
        .WIDTH   (DLY_W)
    ) u_sync_delay (
        .clk      (clk),
        .reset    (reset),
        .pix_en   (pix_en),
        .data_in  (dly_in),
        .data_out (dly_out)
    );

    // ------------------------------------------------------------------
    // Colour source selection
    // ------------------------------------------------------------------
    rgb_t pix_sel;

    always_comb begin
        pix_sel.r = red_in;
        pix_sel.g = green_in;
        pix_sel.b = blue_in;
`ifdef LCD_TEST_PATTERN_EN
        // Bars come from the delayed column, so they line up exactly where
        // renderer pixels of the same column would.
        if (pattern_sel) begin
            pix_sel = bar_colour(dly_bar);
        end
`endif
    end

`ifndef LCD_TEST_PATTERN_EN
    // Without the pattern generator the select input has no function.
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
`endif

    // ------------------------------------------------------------------
    // Output register: timing and colour launched together to the pins
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            lcd_hsync <= sync_inactive(SYNC_POL);
            lcd_vsync <= sync_inactive(SYNC_POL);
            lcd_de    <= 1'b0;
            lcd_r     <= 8'h00;
            lcd_g     <= 8'h00;
            lcd_b     <= 8'h00;
        end else if (pix_en) begin
            lcd_hsync <= dly_timing.hs ? sync_active(SYNC_POL) : sync_inactive(SYNC_POL);
            lcd_vsync <= dly_timing.vs ? sync_active(SYNC_POL) : sync_inactive(SYNC_POL);
            lcd_de    <= dly_timing.de;
            // Blanking is always black regardless of what the renderer sends.
            lcd_r     <= dly_timing.de ? pix_sel.r : 8'h00;
            lcd_g     <= dly_timing.de ? pix_sel.g : 8'h00;
            lcd_b     <= dly_timing.de ? pix_sel.b : 8'h00;
        end
    end

endmodule

// File: tb/tb_lcd_video_timing.sv
// ---------------------------------------------------------------------------
// tb_lcd_video_timing
//   Self-checking bench for lcd_video_timing. Horizontal timing uses the
//   640/16/96/48 defaults; the frame is shortened to 15 lines so whole
//   frames fit in a short run. PIX_LATENCY is 2 to exercise a multi-stage
//   alignment pipeline. A model renderer returns per-pixel colours derived
//   from the pixel index so any misalignment shows up on lcd_r/g/b.
//   Optional macro honoured: LCD_TEST_PATTERN_EN.
// ---------------------------------------------------------------------------
module tb_lcd_video_timing;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int HT = HA + HF + HS + HB;          // 800
    localparam int VA = 8, VF = 2, VS = 2, VB = 3;
    localparam int VT = VA + VF + VS + VB;          // 15
    localparam int FRAME = HT * VT;                 // 12000
    localparam int PL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic        pattern_sel = 1'b0;
    logic [7:0]  red_in = 8'h00, green_in = 8'h00, blue_in = 8'h00;
    logic [11:0] CounterX, CounterY;
    logic        FrameStart, lcd_hsync, lcd_vsync, lcd_de;
    logic [7:0]  lcd_r, lcd_g, lcd_b;

    int vectors = 0;
    int miscompares = 0;
    int idx = 0;            // pix_en edges since reset = linear counter position

    int err_x, err_y, err_fs, err_de, err_hs, err_vs, err_rgb;
    int hs_falls, hs_bad_pos, hs_bad_len, vs_low, de_high;
    int fs_t[$];

    always #5 clk = ~clk;

    lcd_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .PIX_LATENCY(PL)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .pattern_sel(pattern_sel),
        .CounterX(CounterX), .CounterY(CounterY), .FrameStart(FrameStart),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b)
    );

    // ---------------- model renderer and expected pins ----------------
    function automatic logic [7:0] ren_r(input int p); return 8'(p);          endfunction
    function automatic logic [7:0] ren_g(input int p); return 8'(p / 3);      endfunction
    function automatic logic [7:0] ren_b(input int p); return 8'(p * 5 + 7);  endfunction

    function automatic logic e_de(input int i);
        int p;
        p = i - PL - 1;
        if (p < 0) return 1'b0;
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    function automatic logic e_hs(input int i);
        int p;
        p = i - PL - 1;
        if (p < 0) return 1'b1;
        return !(((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS));
    endfunction

    function automatic logic e_vs(input int i);
        int p;
        p = i - PL - 1;
        if (p < 0) return 1'b1;
        return !((((p / HT) % VT) >= VA + VF) && (((p / HT) % VT) < VA + VF + VS));
    endfunction

    function automatic logic [23:0] e_rgb(input int i);
        int p;
        p = i - PL - 1;
        if (!e_de(i)) return 24'h000000;
        return {ren_r(p), ren_g(p), ren_b(p)};
    endfunction

    task automatic drive_renderer();
        int p;
        p = idx - PL;
        red_in   = ren_r(p);
        green_in = ren_g(p);
        blue_in  = ren_b(p);
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step(input logic en);
        pix_en = en;
        @(posedge clk); #1;
        if (en) idx++;
        drive_renderer();
    endtask

    task automatic advance_to(input int target);
        while (idx < target) step(1'b1);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        pix_en = 1'b1;
        @(posedge clk); #1;
        idx = 0;
        reset = 1'b0;
        drive_renderer();
        #1;
    endtask

    task automatic run_monitor(input int ncycles, input bit toggle);
        logic prev_hs;
        logic en;
        int   fall_i;
        prev_hs = 1'b1; fall_i = 0;
        err_x = 0; err_y = 0; err_fs = 0; err_de = 0; err_hs = 0; err_vs = 0; err_rgb = 0;
        hs_falls = 0; hs_bad_pos = 0; hs_bad_len = 0; vs_low = 0; de_high = 0;
        fs_t.delete();
        for (int t = 0; t < ncycles; t++) begin
            en = toggle ? ((t % 2) == 0) : 1'b1;
            pix_en = en;
            #1;
            if (CounterX !== 12'(idx % HT)) err_x++;
            if (CounterY !== 12'((idx / HT) % VT)) err_y++;
            if (FrameStart !== (en && ((idx % FRAME) == 0))) err_fs++;
            if (lcd_de !== e_de(idx)) err_de++;
            if (lcd_hsync !== e_hs(idx)) err_hs++;
            if (lcd_vsync !== e_vs(idx)) err_vs++;
            if ({lcd_r, lcd_g, lcd_b} !== e_rgb(idx)) err_rgb++;
            if (FrameStart === 1'b1) fs_t.push_back(t);
            if (lcd_de === 1'b1) de_high++;
            if (lcd_vsync === 1'b0) vs_low++;
            if (prev_hs && lcd_hsync === 1'b0) begin
                hs_falls++;
                fall_i = idx;
                if (((idx - PL - 1) % HT) != HA + HF) hs_bad_pos++;
            end
            if (!prev_hs && lcd_hsync === 1'b1) begin
                if (idx - fall_i != HS) hs_bad_len++;
            end
            prev_hs = (lcd_hsync === 1'b1);
            if (!toggle && idx == HT - 1) begin
                check("line_end_x", CounterX, HT - 1);
                check("line_end_y", CounterY, 0);
            end
            if (!toggle && idx == HT) begin
                check("wrap_x", CounterX, 0);
                check("wrap_y", CounterY, 1);
            end
            if (!toggle && idx == FRAME) begin
                check("frame_wrap_x", CounterX, 0);
                check("frame_wrap_y", CounterY, 0);
            end
            @(posedge clk); #1;
            if (en) idx++;
            drive_renderer();
        end
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        int   x;
        int   y;
        logic de;
        logic hs;
        logic vs;
    } tvec_t;

    typedef struct {
        int          x;
        logic [23:0] rgb;
    } pvec_t;

    tvec_t tv[14];
    pvec_t pv[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int spacing;

        // Pin levels with SYNC_POL=0: sync pins read 0 while active.
        tv[0]  = '{x:0,   y:0,  de:1'b1, hs:1'b1, vs:1'b1};
        tv[1]  = '{x:639, y:0,  de:1'b1, hs:1'b1, vs:1'b1};
        tv[2]  = '{x:640, y:0,  de:1'b0, hs:1'b1, vs:1'b1};
        tv[3]  = '{x:655, y:0,  de:1'b0, hs:1'b1, vs:1'b1};
        tv[4]  = '{x:656, y:0,  de:1'b0, hs:1'b0, vs:1'b1};
        tv[5]  = '{x:751, y:0,  de:1'b0, hs:1'b0, vs:1'b1};
        tv[6]  = '{x:752, y:0,  de:1'b0, hs:1'b1, vs:1'b1};
        tv[7]  = '{x:100, y:7,  de:1'b1, hs:1'b1, vs:1'b1};
        tv[8]  = '{x:799, y:7,  de:1'b0, hs:1'b1, vs:1'b1};
        tv[9]  = '{x:0,   y:8,  de:1'b0, hs:1'b1, vs:1'b1};
        tv[10] = '{x:0,   y:10, de:1'b0, hs:1'b1, vs:1'b0};
        tv[11] = '{x:700, y:10, de:1'b0, hs:1'b0, vs:1'b0};
        tv[12] = '{x:799, y:11, de:1'b0, hs:1'b1, vs:1'b0};
        tv[13] = '{x:0,   y:12, de:1'b0, hs:1'b1, vs:1'b1};

`ifdef LCD_TEST_PATTERN_EN
        pv[0] = '{x:0,   rgb:24'h000000};
        pv[1] = '{x:127, rgb:24'h000000};
        pv[2] = '{x:128, rgb:24'h0000FF};
        pv[3] = '{x:300, rgb:24'h00FF00};
        pv[4] = '{x:639, rgb:24'hFF0000};
        pv[5] = '{x:640, rgb:24'h000000};
        pv[6] = '{x:700, rgb:24'h000000};
`else
        pv[0] = '{x:0,   rgb:{ren_r(0),   ren_g(0),   ren_b(0)}};
        pv[1] = '{x:127, rgb:{ren_r(127), ren_g(127), ren_b(127)}};
        pv[2] = '{x:128, rgb:{ren_r(128), ren_g(128), ren_b(128)}};
        pv[3] = '{x:300, rgb:{ren_r(300), ren_g(300), ren_b(300)}};
        pv[4] = '{x:639, rgb:{ren_r(639), ren_g(639), ren_b(639)}};
        pv[5] = '{x:640, rgb:24'h000000};
        pv[6] = '{x:700, rgb:24'h000000};
`endif

        // ---- reset state ----
        reset = 1'b1;
        pix_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", CounterX, 0);
        check("rst_y", CounterY, 0);
        check("rst_framestart", FrameStart, 0);
        check("rst_de", lcd_de, 0);
        check("rst_rgb", {lcd_r, lcd_g, lcd_b}, 0);
        check("rst_hsync", lcd_hsync, 1);
        check("rst_vsync", lcd_vsync, 1);
        reset = 1'b0;
        idx = 0;
        drive_renderer();
        #1;
        check("rel_framestart", FrameStart, 1);

        // ---- table-driven probe points ----
        for (int i = 0; i < 14; i++) begin
            advance_to(tv[i].y * HT + tv[i].x + PL + 1);
            check($sformatf("tbl%0d_de", i), lcd_de, tv[i].de);
            check($sformatf("tbl%0d_hs", i), lcd_hsync, tv[i].hs);
            check($sformatf("tbl%0d_vs", i), lcd_vsync, tv[i].vs);
            check($sformatf("tbl%0d_rgb", i), {lcd_r, lcd_g, lcd_b},
                  tv[i].de ? {ren_r(tv[i].y * HT + tv[i].x), ren_g(tv[i].y * HT + tv[i].x),
                              ren_b(tv[i].y * HT + tv[i].x)} : 24'h000000);
        end

        // ---- two continuous frames ----
        apply_reset();
        run_monitor(2 * FRAME + PL + 1, 1'b0);
        check("cont_x_errs", err_x, 0);
        check("cont_y_errs", err_y, 0);
        check("cont_fs_errs", err_fs, 0);
        check("cont_de_errs", err_de, 0);
        check("cont_hs_errs", err_hs, 0);
        check("cont_vs_errs", err_vs, 0);
        check("cont_rgb_errs", err_rgb, 0);
        check("cont_fs_pulses", fs_t.size(), 3);
        spacing = (fs_t.size() >= 2) ? fs_t[1] - fs_t[0] : -1;
        check("cont_fs_spacing", spacing, FRAME);
        check("hs_falls", hs_falls, 2 * VT);
        check("hs_fall_pos_errs", hs_bad_pos, 0);
        check("hs_low_len_errs", hs_bad_len, 0);
        check("vs_low_cycles", vs_low, 2 * VS * HT);
        check("de_cycles", de_high, 2 * HA * VA);

        // ---- pix_en toggling 1/0 ----
        apply_reset();
        run_monitor(2 * FRAME + 2, 1'b1);
        check("tog_x_errs", err_x, 0);
        check("tog_y_errs", err_y, 0);
        check("tog_fs_errs", err_fs, 0);
        check("tog_de_errs", err_de, 0);
        check("tog_hs_errs", err_hs, 0);
        check("tog_vs_errs", err_vs, 0);
        check("tog_rgb_errs", err_rgb, 0);
        spacing = (fs_t.size() >= 2) ? fs_t[1] - fs_t[0] : -1;
        check("tog_frame_clks", spacing, 2 * FRAME);

        // ---- reset in mid-frame ----
        apply_reset();
        advance_to(5 * HT + 300);
        check("mid_x", CounterX, 300);
        check("mid_y", CounterY, 5);
        check("mid_de", lcd_de, 1);
        reset = 1'b1;
        pix_en = 1'b1;
        @(posedge clk); #1;
        check("midrst_de", lcd_de, 0);
        check("midrst_rgb", {lcd_r, lcd_g, lcd_b}, 0);
        check("midrst_hsync", lcd_hsync, 1);
        check("midrst_vsync", lcd_vsync, 1);
        check("midrst_fs", FrameStart, 0);
        reset = 1'b0;
        idx = 0;
        drive_renderer();
        #1;
        check("midrel_x", CounterX, 0);
        check("midrel_y", CounterY, 0);
        check("midrel_fs", FrameStart, 1);
        step(1'b1);
        check("midrel_next_x", CounterX, 1);
        check("midrel_next_fs", FrameStart, 0);

        // ---- colour bars (or pass-through without the feature) ----
        apply_reset();
        pattern_sel = 1'b1;
        for (int i = 0; i < 7; i++) begin
            advance_to(pv[i].x + PL + 1);
            check($sformatf("pat_x%0d_rgb", pv[i].x), {lcd_r, lcd_g, lcd_b}, pv[i].rgb);
        end
        pattern_sel = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
